// File: rtl/math_adder_multiword_seq.sv
// -----------------------------------------------------------------------------
// math_adder_multiword_seq
//   Multi-cycle WIDTH-bit adder/subtractor built around one CHUNK-bit ripple
//   carry adder. An accepted operation is processed one chunk per clock,
//   least-significant chunk first, with the carry threaded between passes
//   through a register. Result latency is exactly NCHUNK cycles after accept.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   request handshake (o_ready only in IDLE)
//   i_a, i_b            WIDTH-bit operands
//   i_c                 carry-in (add only)
//   i_sub               1: a - b, 0: a + b + c
//   o_valid / i_ready   result handshake (o_valid held in DONE)
//   o_sum               WIDTH-bit result, modulo 2^WIDTH
//   o_carry             final carry-out (subtract: 1 = no borrow)
//   o_ovf               two's-complement overflow
//   o_busy              high whenever not IDLE
// -----------------------------------------------------------------------------

// Plain CHUNK-bit ripple carry adder; one full-adder cell per bit.
module math_adder_ripple_carry #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);
    logic [N:0] c;

    assign c[0] = i_c;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
        assign c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_carry = c[N];
endmodule

module math_adder_multiword_seq #(
    parameter int CHUNK  = 8,
    parameter int NCHUNK = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [CHUNK*NCHUNK-1:0]  i_a,
    input  logic [CHUNK*NCHUNK-1:0]  i_b,
    input  logic                     i_c,
    input  logic                     i_sub,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [CHUNK*NCHUNK-1:0]  o_sum,
    output logic                     o_carry,
    output logic                     o_ovf,
    output logic                     o_busy
);
    localparam int WIDTH = CHUNK * NCHUNK;
    localparam int IDXW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands and result held as chunk arrays so a pass selects a whole chunk.
    logic [NCHUNK-1:0][CHUNK-1:0] a_q;
    logic [NCHUNK-1:0][CHUNK-1:0] b_q;    // already inverted for subtract
    logic [NCHUNK-1:0][CHUNK-1:0] sum_q;
    logic                         carry_q;
    logic [IDXW-1:0]              idx;

    logic [CHUNK-1:0] add_sum;
    logic             add_co;
    logic             accept;
    logic             last;

    assign accept = i_valid && (state == IDLE);
    assign last   = (idx == IDXW'(NCHUNK - 1));

    // The single shared adder: every pass of an operation goes through it.
    math_adder_ripple_carry #(.N(CHUNK)) u_add (
        .i_a     (a_q[idx]),
        .i_b     (b_q[idx]),
        .i_c     (carry_q),
        .o_sum   (add_sum),
        .o_carry (add_co)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b1;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. Inputs are only sampled on the accept edge, so anything the
    // requester does afterwards cannot disturb the operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            o_carry <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= i_a;
                // Subtract as a + ~b + 1: invert b here, seed the carry with 1.
                b_q     <= i_b ^ {WIDTH{i_sub}};
                carry_q <= i_sub ? 1'b1 : i_c;
                idx     <= '0;
            end else if (state == RUN) begin
                sum_q[idx] <= add_sum;
                carry_q    <= add_co;
                idx        <= idx + 1'b1;
                if (last) begin
                    o_carry <= add_co;
                    // Same-sign operands producing a different-sign result.
                    o_ovf   <= (a_q[NCHUNK-1][CHUNK-1] == b_q[NCHUNK-1][CHUNK-1]) &&
                               (add_sum[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                end
            end
        end
    end

    assign o_sum = sum_q;
endmodule

// File: tb/tb_math_adder_multiword_seq.sv
// -----------------------------------------------------------------------------
// tb_math_adder_multiword_seq
//   Two instances share clock and reset: index 0 is CHUNK=8/NCHUNK=4, index 1
//   is CHUNK=32/NCHUNK=1. Both are 32 bits wide so one reference model serves.
// -----------------------------------------------------------------------------
module tb_math_adder_multiword_seq;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         valid   [2];
    logic         rdy_in  [2];
    logic         c_in    [2];
    logic         sub     [2];
    logic [W-1:0] a       [2];
    logic [W-1:0] b       [2];
    logic         ready_o [2];
    logic         ovalid  [2];
    logic         carry   [2];
    logic         ovf     [2];
    logic         busy    [2];
    logic [W-1:0] sum     [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    math_adder_multiword_seq #(.CHUNK(8), .NCHUNK(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready_o[0]),
        .i_a(a[0]), .i_b(b[0]), .i_c(c_in[0]), .i_sub(sub[0]),
        .o_valid(ovalid[0]), .i_ready(rdy_in[0]), .o_sum(sum[0]),
        .o_carry(carry[0]), .o_ovf(ovf[0]), .o_busy(busy[0])
    );

    math_adder_multiword_seq #(.CHUNK(32), .NCHUNK(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready_o[1]),
        .i_a(a[1]), .i_b(b[1]), .i_c(c_in[1]), .i_sub(sub[1]),
        .o_valid(ovalid[1]), .i_ready(rdy_in[1]), .o_sum(sum[1]),
        .o_carry(carry[1]), .o_ovf(ovf[1]), .o_busy(busy[1])
    );

    // Reference: unsigned 33-bit arithmetic for sum/carry, signed 64-bit
    // arithmetic for overflow (result outside the 32-bit signed range).
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input logic ms,
                                  output logic [W-1:0] es, output logic ec,
                                  output logic eo);
        logic [W:0] u;
        longint     r;
        if (!ms) begin
            u  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            es = u[W-1:0];
            ec = u[W];
            r  = longint'($signed(ma)) + longint'($signed(mb)) + (mc ? 64'sd1 : 64'sd0);
        end else begin
            es = ma - mb;
            ec = (ma >= mb);
            r  = longint'($signed(ma)) - longint'($signed(mb));
        end
        eo = (r > SMAX) || (r < SMIN);
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 4 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for o_ready, presents the request and clocks the accept edge.
    task automatic start_op(input int sel, input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tc, input logic ts);
        int g;
        g = 0;
        while (!ready_o[sel] && g < 100) begin
            tick();
            g++;
        end
        if (!ready_o[sel]) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_wait[%0d]: o_ready=%b required 1 within 100 cycles", sel, ready_o[sel]);
        end
        a[sel] = ta; b[sel] = tb; c_in[sel] = tc; sub[sel] = ts;
        valid[sel] = 1'b1;
        tick();
        valid[sel] = 1'b0;
    endtask

    task automatic wait_valid(input int sel, output int lat);
        lat = 0;
        while (!ovalid[sel] && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result(input int sel);
        valid[sel]  = 1'b0;
        rdy_in[sel] = 1'b1;
        tick();
        rdy_in[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({ovalid[s], ready_o[s], busy[s], carry[s], ovf[s]} !== 5'b01000 || sum[s] !== '0) begin
                n_err++;
                $display("FAIL reset[%0d]: valid/ready/busy/carry/ovf=%b sum=%h required 01000 sum=0",
                         s, {ovalid[s], ready_o[s], busy[s], carry[s], ovf[s]}, sum[s]);
            end
        end
        rst_n = 1'b1;
    endtask

    // Runs immediately after reset release: the accept must land on the first edge.
    task automatic test_wrap();
        int lat;
        if (!ready_o[0]) begin
            n_cmp++; n_err++;
            $display("FAIL first_accept: o_ready=%b required 1", ready_o[0]);
        end
        start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy[0] !== 1'b1 || ovalid[0] !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_busy cyc%0d: busy=%b valid=%b required 1 0", i, busy[0], ovalid[0]);
            end
            tick();
            lat++;
        end
        n_cmp++;
        if (ovalid[0] !== 1'b1 || sum[0] !== 32'h0 || carry[0] !== 1'b1 || ovf[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_result: valid=%b sum=%h c=%b v=%b busy=%b required 1 00000000 1 0 1",
                     ovalid[0], sum[0], carry[0], ovf[0], busy[0]);
        end
        release_result(0);
    endtask

    task automatic test_sub();
        int lat;
        start_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        wait_valid(0, lat);
        n_cmp++;
        if (lat != 4 || sum[0] !== 32'hFFFF_FFFE || carry[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sub_5_7: lat=%0d sum=%h c=%b v=%b required 4 fffffffe 0 0",
                     lat, sum[0], carry[0], ovf[0]);
        end
        release_result(0);
    endtask

    task automatic test_ovf();
        int lat;
        start_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_valid(0, lat);
        n_cmp++;
        if (lat != 4 || sum[0] !== 32'h8000_0000 || carry[0] !== 1'b0 || ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_add: lat=%0d sum=%h c=%b v=%b required 4 80000000 0 1",
                     lat, sum[0], carry[0], ovf[0]);
        end
        release_result(0);
        start_op(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        wait_valid(0, lat);
        n_cmp++;
        if (lat != 4 || sum[0] !== 32'h7FFF_FFFF || carry[0] !== 1'b1 || ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_sub: lat=%0d sum=%h c=%b v=%b required 4 7fffffff 1 1",
                     lat, sum[0], carry[0], ovf[0]);
        end
        release_result(0);
    endtask

    task automatic test_hold();
        int         lat;
        logic [W-1:0] ta, tb, es;
        logic       ec, eo;
        ta = $urandom; tb = $urandom;
        model(ta, tb, 1'b1, 1'b0, es, ec, eo);
        start_op(0, ta, tb, 1'b1, 1'b0);
        wait_valid(0, lat);
        rdy_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (ovalid[0] !== 1'b1 || ready_o[0] !== 1'b0 || sum[0] !== es ||
                carry[0] !== ec || ovf[0] !== eo) begin
                n_err++;
                $display("FAIL hold cyc%0d: valid=%b ready=%b sum=%h c=%b v=%b required 1 0 %h %b %b",
                         i, ovalid[0], ready_o[0], sum[0], carry[0], ovf[0], es, ec, eo);
            end
            if (i == 3) begin
                a[0] = ~ta; b[0] = ~tb; sub[0] = 1'b1; valid[0] = 1'b1;
            end else begin
                valid[0] = 1'b0;
            end
            tick();
        end
        release_result(0);
        n_cmp++;
        if (ovalid[0] !== 1'b0 || ready_o[0] !== 1'b1 || sum[0] !== es || carry[0] !== ec || ovf[0] !== eo) begin
            n_err++;
            $display("FAIL hold_release: valid=%b ready=%b sum=%h required 0 1 %h",
                     ovalid[0], ready_o[0], sum[0], es);
        end
        tick();
        n_cmp++;
        if (ready_o[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hold_idle: ready=%b busy=%b required 1 0", ready_o[0], busy[0]);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        start_op(0, 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ovalid[0], ready_o[0], busy[0], carry[0], ovf[0]} !== 5'b01000 || sum[0] !== '0) begin
            n_err++;
            $display("FAIL abort_reset: valid/ready/busy/carry/ovf=%b sum=%h required 01000 0",
                     {ovalid[0], ready_o[0], busy[0], carry[0], ovf[0]}, sum[0]);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ovalid[0] !== 1'b0) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0 || ready_o[0] !== 1'b1 || sum[0] !== '0) begin
            n_err++;
            $display("FAIL abort_quiet: valid_cycles=%0d ready=%b sum=%h required 0 1 0", seen, ready_o[0], sum[0]);
        end
        start_op(0, 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
        wait_valid(0, lat);
        n_cmp++;
        if (lat != 4 || sum[0] !== 32'h0202_0202 || carry[0] !== 1'b0 || ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_next: lat=%0d sum=%h c=%b v=%b required 4 02020202 0 0",
                     lat, sum[0], carry[0], ovf[0]);
        end
        release_result(0);
    endtask

    task automatic test_random(input int sel, input int nops);
        int           lat;
        logic [W-1:0] ta, tb, es;
        logic         tc, ts, ec, eo;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 2)) begin
                a[sel] = $urandom; valid[sel] = 1'b0;
                tick();
            end
            ta = $urandom; tb = $urandom;
            case ($urandom_range(0, 7))
                0: ta = 32'hFFFF_FFFF;
                1: tb = 32'h8000_0000;
                2: tb = ta;
                default: ;
            endcase
            tc = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            model(ta, tb, tc, ts, es, ec, eo);
            start_op(sel, ta, tb, tc, ts);
            lat = 0;
            while (!ovalid[sel] && lat < 64) begin
                valid[sel] = 1'($urandom_range(0, 1));
                a[sel] = $urandom; b[sel] = $urandom;
                c_in[sel] = ~tc; sub[sel] = ~ts;
                tick();
                lat++;
            end
            repeat ($urandom_range(0, 3)) begin
                valid[sel] = 1'($urandom_range(0, 1));
                tick();
            end
            valid[sel] = 1'b0;
            n_cmp++;
            if (lat != lat_of(sel)) begin
                n_err++;
                $display("FAIL rand_lat[%0d] op%0d: lat=%0d required %0d", sel, n, lat, lat_of(sel));
            end
            n_cmp++;
            if (ovalid[sel] !== 1'b1 || sum[sel] !== es || carry[sel] !== ec || ovf[sel] !== eo) begin
                n_err++;
                $display("FAIL rand_res[%0d] op%0d: a=%h b=%h c=%b sub=%b got %b %h %b %b required 1 %h %b %b",
                         sel, n, ta, tb, tc, ts, ovalid[sel], sum[sel], carry[sel], ovf[sel], es, ec, eo);
            end
            release_result(sel);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; rdy_in[s] = 1'b0; c_in[s] = 1'b0; sub[s] = 1'b0;
            a[s] = '0; b[s] = '0;
        end
        test_reset();
        test_wrap();
        test_sub();
        test_ovf();
        test_hold();
        test_reset_abort();
        test_random(0, 1000);
        test_random(1, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/math_adder_multiword_seq.md
MATH_ADDER_MULTIWORD_SEQ -- requirements
Module: math_adder_multiword_seq

Interface
REQ-001 SHALL have parameter CHUNK, default 8: width of one adder pass, in bits; legal values are 1 or greater.
REQ-002 SHALL have parameter NCHUNK, default 4: number of passes per operation; legal values are 1 or greater.
REQ-003 SHALL define local parameter WIDTH = CHUNK*NCHUNK, the full operand width.
REQ-004 SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-005 SHALL provide i_clk, input, 1: the clock.
REQ-006 SHALL provide i_rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL provide i_valid, input, 1: an operation request is present.
REQ-008 SHALL provide o_ready, output, 1: the block can accept a request.
REQ-009 SHALL provide i_a and i_b, input, WIDTH each: the operands.
REQ-010 SHALL provide i_c, input, 1: carry-in, used for add only.
REQ-011 SHALL provide i_sub, input, 1: 1 selects subtract (a - b); 0 selects add (a + b + c).
REQ-012 SHALL provide o_valid, output, 1: a result is held.
REQ-013 SHALL provide i_ready, input, 1: downstream accepts the result.
REQ-014 SHALL provide o_sum, output, WIDTH: the result.
REQ-015 SHALL provide o_carry, output, 1: final carry-out (for subtract, 1 means no borrow).
REQ-016 SHALL provide o_ovf, output, 1: two's-complement overflow.
REQ-017 SHALL provide o_busy, output, 1: high in any state other than IDLE.

Function
REQ-018 SHALL instantiate exactly one math_adder_ripple_carry with N=CHUNK and SHALL share it across all passes of an operation.
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-020 SHALL drive o_ready=1 only in IDLE; there is no overlap of operations.
REQ-021 SHALL accept a request on the clock edge where i_valid and o_ready are both 1, and on that edge SHALL:
- latch i_a;
- latch i_b XOR {WIDTH{i_sub}};
- set the carry register to (i_sub ? 1 : i_c);
- clear the chunk index to 0;
- go to RUN.
REQ-022 In RUN, on each edge the block SHALL:
- feed chunk[idx] of both latched operands and the carry register to the adder;
- write the adder sum into o_sum chunk[idx];
- load the adder carry-out into the carry register;
- increment idx.
REQ-023 SHALL go from RUN to DONE on the edge that processes idx=NCHUNK-1, load o_carry from the final carry-out and assert o_valid on that edge; latency is exactly NCHUNK cycles from the accept edge to o_valid=1.
REQ-024 SHALL compute o_ovf on the final pass as (a_msb == b'_msb) AND (sum_msb != a_msb), where b' is the latched, possibly inverted, operand.
REQ-025 In DONE, SHALL hold o_sum, o_carry and o_ovf stable while i_ready=0.
REQ-026 SHALL go from DONE to IDLE when i_ready=1, deassert o_valid on that edge and keep o_sum/o_carry/o_ovf until the next accept.
REQ-027 SHALL ignore i_valid in RUN and DONE, with no state or data change.
REQ-028 SHALL, for NCHUNK=1, take one RUN cycle (latency 1), with identical behaviour otherwise.
REQ-029 SHALL let arithmetic wrap modulo 2^WIDTH; any carry beyond the MSB appears only on o_carry.
REQ-030 SHALL NOT let input changes after the accept edge affect the current operation.

Reset
REQ-031 While i_rst_n=0, asynchronously and regardless of state, SHALL:
- set the state to IDLE;
- clear idx, the carry register, operand registers, o_sum, o_carry, o_ovf and o_valid to 0;
- drive o_busy=0 and o_ready=1.
REQ-032 SHALL treat reset asserted mid-RUN or in DONE as aborting the operation, producing no result and no o_valid pulse.
REQ-033 SHALL accept a request on the first clock edge after reset deasserts.

Verification (CHUNK=8, NCHUNK=4)
REQ-034 Bench SHALL apply a=0xFFFFFFFF, b=0x00000001, c=0, sub=0, then i_ready=1 -> o_valid exactly 4 cycles after accept, sum=0x00000000, carry=1, ovf=0, o_busy high for 4 cycles then DONE.
REQ-035 Bench SHALL apply a=0x00000005, b=0x00000007, sub=1, c=1 -> sum=0xFFFFFFFE, carry=0, ovf=0; i_c has no effect.
REQ-036 Bench SHALL apply a=0x7FFFFFFF, b=0x00000001, add, c=0 -> sum=0x80000000, carry=0, ovf=1; then a=0x80000000 minus 1 -> sum=0x7FFFFFFF, carry=1, ovf=1.
REQ-037 Bench SHALL, after a result, hold i_ready=0 for 10 cycles and pulse i_valid with new operands -> o_sum/o_carry/o_ovf stable, o_ready=0, new request ignored; i_ready=1 -> IDLE, o_ready=1 next cycle.
REQ-038 Bench SHALL assert i_rst_n=0 after 2 RUN cycles of a=0x01010101+0x01010101, then release -> all outputs 0, o_ready=1, o_valid never asserted; the next request completes correctly (sum=0x02020202).
REQ-039 Bench SHALL run 1000 random operations with random i_valid/i_ready stalls, comparing sum/carry/ovf with a WIDTH-bit model, and SHALL repeat with NCHUNK=1 -> zero mismatches and latency 1.
